// File: rtl/lp_buf_pingpong_ctrl.sv
// Ping-pong BRAM sequencer: writes one framed symbol per bank and replays it one
// symbol later under downstream back-pressure, with dout-aligned vld/sop/eop.
module lp_buf_pingpong_ctrl #(
   parameter int unsigned ADDR_WIDTH = 11,
   parameter int unsigned RD_LAT     = 2
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_wr_vld,
   input  logic                  i_wr_sop,
   input  logic                  i_wr_eop,
   input  logic                  i_rd_ready,
   output logic                  o_mem_wen,
   output logic [ADDR_WIDTH:0]   o_mem_waddr,
   output logic                  o_mem_ren,
   output logic [ADDR_WIDTH:0]   o_mem_raddr,
   output logic                  o_rd_vld,
   output logic                  o_rd_sop,
   output logic                  o_rd_eop,
   output logic [1:0]            o_bank_full,
   output logic                  o_overflow,
   output logic                  o_frame_err
);

   localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_e;
   typedef enum logic       {R_IDLE, R_RUN}          rstate_e;

   wstate_e             wstate_q, wstate_d;
   logic                wbank_q, wbank_d;
   logic [ADDR_WIDTH:0] wcnt_q, wcnt_d;
   logic [ADDR_WIDTH:0] len_q [2];
   logic [ADDR_WIDTH:0] len_d [2];
   logic [1:0]          full_q, full_d;
   logic                overflow_q, overflow_d;
   logic                frame_err_q, frame_err_d;

   rstate_e             rstate_q, rstate_d;
   logic                rbank_q, rbank_d;
   logic [ADDR_WIDTH:0] rcnt_q, rcnt_d;
   logic [2:0]          tag_sr_q [RD_LAT];
   logic [2:0]          tag_sr_d [RD_LAT];

   logic                wr_restart, wr_fill;
   logic [1:0]          wr_set;
   logic                rd_ren, rd_sop, rd_eop;
   logic [1:0]          rd_clr;

   // ---------------- write FSM: state register ----------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wstate_q    <= W_IDLE;
         wbank_q     <= 1'b0;
         wcnt_q      <= '0;
         len_q[0]    <= '0;
         len_q[1]    <= '0;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         wstate_q    <= wstate_d;
         wbank_q     <= wbank_d;
         wcnt_q      <= wcnt_d;
         len_q[0]    <= len_d[0];
         len_q[1]    <= len_d[1];
         overflow_q  <= overflow_d;
         frame_err_q <= frame_err_d;
      end
   end

   // ---------------- write FSM: next state ----------------
   always_comb begin
      logic                fin;
      logic [ADDR_WIDTH:0] fin_len;
      wstate_d    = wstate_q;
      wbank_d     = wbank_q;
      wcnt_d      = wcnt_q;
      len_d[0]    = len_q[0];
      len_d[1]    = len_q[1];
      overflow_d  = overflow_q;
      frame_err_d = frame_err_q;
      wr_set      = 2'b00;
      fin         = 1'b0;
      fin_len     = CNT_ONE;
      unique case (wstate_q)
         W_IDLE: begin
            if (i_wr_vld && i_wr_sop) begin
               if (!full_q[wbank_q]) begin
                  wcnt_d   = CNT_ONE;
                  wstate_d = W_FILL;
                  fin      = i_wr_eop;
               end else begin
                  overflow_d = 1'b1;
                  wstate_d   = i_wr_eop ? W_IDLE : W_DROP;
               end
            end else if (i_wr_vld && i_wr_eop) begin
               frame_err_d = 1'b1;
            end
         end
         W_FILL: begin
            if (i_wr_vld) begin
               if (i_wr_sop) begin
                  // abandon the partial symbol and restart it at the bank base
                  frame_err_d = 1'b1;
                  wcnt_d      = CNT_ONE;
                  fin         = i_wr_eop;
               end else if (wcnt_q == DEPTH_C) begin
                  frame_err_d = 1'b1;
                  wstate_d    = i_wr_eop ? W_IDLE : W_DROP;
               end else begin
                  wcnt_d  = wcnt_q + CNT_ONE;
                  fin     = i_wr_eop;
                  fin_len = wcnt_q + CNT_ONE;
               end
            end
         end
         W_DROP: begin
            if (i_wr_vld && i_wr_eop) wstate_d = W_IDLE;
         end
         default: wstate_d = W_IDLE;
      endcase
      if (fin) begin
         len_d[wbank_q]  = fin_len;
         wr_set[wbank_q] = 1'b1;
         wbank_d         = ~wbank_q;
         wstate_d        = W_IDLE;
      end
   end

   // ---------------- write FSM: outputs ----------------
   always_comb begin
      wr_restart = 1'b0;
      wr_fill    = 1'b0;
      unique case (wstate_q)
         W_IDLE:  wr_restart = i_wr_vld & i_wr_sop & ~full_q[wbank_q];
         W_FILL: begin
            wr_restart = i_wr_vld & i_wr_sop;
            wr_fill    = i_wr_vld & ~i_wr_sop & (wcnt_q != DEPTH_C);
         end
         default: ;
      endcase
      o_mem_wen   = ~i_reset & (wr_restart | wr_fill);
      o_mem_waddr = {wbank_q, wcnt_q[ADDR_WIDTH-1:0]};
      if (wr_restart) o_mem_waddr[ADDR_WIDTH-1:0] = '0;
      if (!o_mem_wen) o_mem_waddr = '0;
   end

   // ---------------- read FSM: state register ----------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         rstate_q <= R_IDLE;
         rbank_q  <= 1'b0;
         rcnt_q   <= '0;
      end else begin
         rstate_q <= rstate_d;
         rbank_q  <= rbank_d;
         rcnt_q   <= rcnt_d;
      end
   end

   // ---------------- read FSM: next state ----------------
   always_comb begin
      rstate_d = rstate_q;
      rbank_d  = rbank_q;
      rcnt_d   = rcnt_q;
      rd_clr   = 2'b00;
      unique case (rstate_q)
         R_IDLE: begin
            if (full_q[rbank_q]) begin
               rstate_d = R_RUN;
               rcnt_d   = '0;
            end
         end
         R_RUN: begin
            if (rd_ren) begin
               rcnt_d = rcnt_q + CNT_ONE;
               if (rd_eop) begin
                  rd_clr[rbank_q] = 1'b1;
                  rbank_d         = ~rbank_q;
                  rstate_d        = R_IDLE;
               end
            end
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   // ---------------- read FSM: outputs ----------------
   always_comb begin
      rd_ren      = ~i_reset & (rstate_q == R_RUN) & i_rd_ready;
      rd_sop      = (rcnt_q == '0);
      rd_eop      = ((rcnt_q + CNT_ONE) == len_q[rbank_q]);
      o_mem_ren   = rd_ren;
      o_mem_raddr = i_reset ? '0 : {rbank_q, rcnt_q[ADDR_WIDTH-1:0]};
   end

   // Set and clear always target different banks, so one OR/AND-NOT merge suffices.
   always_comb begin
      full_d = (full_q | wr_set) & ~rd_clr;
   end

   always_comb begin
      tag_sr_d[0] = {rd_ren, rd_ren & rd_sop, rd_ren & rd_eop};
      for (int unsigned i = 1; i < RD_LAT; i++) begin
         tag_sr_d[i] = tag_sr_q[i-1];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         full_q <= 2'b00;
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            tag_sr_q[i] <= '0;
         end
      end else begin
         full_q <= full_d;
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            tag_sr_q[i] <= tag_sr_d[i];
         end
      end
   end

   always_comb begin
      o_rd_vld    = tag_sr_q[RD_LAT-1][2];
      o_rd_sop    = tag_sr_q[RD_LAT-1][1];
      o_rd_eop    = tag_sr_q[RD_LAT-1][0];
      o_bank_full = full_q;
      o_overflow  = overflow_q;
      o_frame_err = frame_err_q;
   end

endmodule

// File: tb/tb_lp_buf_pingpong_ctrl.sv
// Scoreboard bench: a symbol-level reference model predicts writes, reads, aligned
// read tags and flags; a negedge monitor pops and compares whenever the DUT acts.
module tb_lp_buf_pingpong_ctrl;
   localparam int AW    = 4;
   localparam int RL    = 2;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1, vld = 1'b0, sop = 1'b0, eop = 1'b0, rdy = 1'b0;
   logic          o_mem_wen, o_mem_ren, o_rd_vld, o_rd_sop, o_rd_eop, o_overflow, o_frame_err;
   logic [AW:0]   o_mem_waddr, o_mem_raddr;
   logic [1:0]    o_bank_full;

   lp_buf_pingpong_ctrl #(.ADDR_WIDTH(AW), .RD_LAT(RL)) dut (
      .i_clk(clk), .i_reset(rst), .i_wr_vld(vld), .i_wr_sop(sop), .i_wr_eop(eop),
      .i_rd_ready(rdy), .o_mem_wen(o_mem_wen), .o_mem_waddr(o_mem_waddr),
      .o_mem_ren(o_mem_ren), .o_mem_raddr(o_mem_raddr), .o_rd_vld(o_rd_vld),
      .o_rd_sop(o_rd_sop), .o_rd_eop(o_rd_eop), .o_bank_full(o_bank_full),
      .o_overflow(o_overflow), .o_frame_err(o_frame_err));

   typedef struct {int t; int a;}              ent_t;
   typedef struct {int t; bit s; bit e;}       oent_t;
   typedef struct {int t; int f; bit o; bit fe;} fent_t;

   ent_t  wq[$], rq[$];
   oent_t oq[$];
   fent_t fq[$];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, errors = 0;
   bit done = 1'b0;
   int rdy_mode = 0;
   bit rdy_tog = 1'b0;

   // reference model state: symbols per bank, one writer position, one reader position
   int m_full[2], m_len[2];
   int m_wbank, m_rbank, m_idx, m_rpos;
   bit m_in, m_drop, m_reading, m_ovf, m_ferr;

   task automatic check(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got %0d expected %0d", nm, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_full = '{0, 0}; m_len = '{0, 0};
      m_wbank = 0; m_rbank = 0; m_idx = 0; m_rpos = 0;
      m_in = 0; m_drop = 0; m_reading = 0; m_ovf = 0; m_ferr = 0;
   endtask

   task automatic model_step(bit v, bit s, bit e, bit r, bit rs);
      int c = cyc;
      bit wr = 0, fin = 0, set_f = 0, clr_f = 0;
      int wa = 0, set_b = 0, set_l = 0, clr_b = 0;
      if (rs) begin
         model_reset();
         while (oq.size() > 0 && oq[$].t > c) void'(oq.pop_back());
         fq.push_back('{c + 1, 0, 1'b0, 1'b0});
         return;
      end
      if (v) begin
         if (!m_in && !m_drop) begin
            if (s) begin
               if (m_full[m_wbank] == 0) begin
                  wr = 1; wa = m_wbank * DEPTH; m_idx = 1; m_in = 1; fin = e;
               end else begin
                  m_ovf = 1; m_drop = !e;
               end
            end else if (e) m_ferr = 1;
         end else if (m_in) begin
            if (s) begin
               m_ferr = 1; wr = 1; wa = m_wbank * DEPTH; m_idx = 1; fin = e;
            end else if (m_idx == DEPTH) begin
               m_ferr = 1; m_in = 0; m_drop = !e;
            end else begin
               wr = 1; wa = m_wbank * DEPTH + m_idx; m_idx++; fin = e;
            end
         end else if (e) m_drop = 0;
      end
      if (wr) wq.push_back('{c, wa});
      if (fin) begin
         set_f = 1; set_b = m_wbank; set_l = m_idx;
         m_wbank ^= 1; m_in = 0;
      end
      if (m_reading) begin
         if (r) begin
            bit ls = (m_rpos == 0);
            bit le = (m_rpos == m_len[m_rbank] - 1);
            rq.push_back('{c, m_rbank * DEPTH + m_rpos});
            oq.push_back('{c + RL, ls, le});
            m_rpos++;
            if (le) begin
               clr_f = 1; clr_b = m_rbank; m_rbank ^= 1; m_reading = 0;
            end
         end
      end else if (m_full[m_rbank] != 0) begin
         m_reading = 1; m_rpos = 0;
      end
      if (set_f) begin m_full[set_b] = 1; m_len[set_b] = set_l; end
      if (clr_f) m_full[clr_b] = 0;
      fq.push_back('{c + 1, m_full[1] * 2 + m_full[0], m_ovf, m_ferr});
   endtask

   task automatic cyc_drive(bit v, bit s, bit e, bit rs);
      bit r;
      case (rdy_mode)
         0: r = 1'b1;
         1: r = 1'b0;
         2: begin r = ~rdy_tog; rdy_tog = r; end
         default: r = ($urandom_range(0, 3) != 0);
      endcase
      @(posedge clk);
      #1;
      vld = v; sop = s; eop = e; rdy = r; rst = rs;
      model_step(v, s, e, r, rs);
   endtask

   task automatic idle(int n);
      for (int k = 0; k < n; k++) cyc_drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic send_sym(int len, bit bubbles);
      for (int k = 0; k < len; k++) begin
         if (bubbles && k > 0 && $urandom_range(0, 3) == 0) cyc_drive(1'b0, 1'b0, 1'b0, 1'b0);
         cyc_drive(1'b1, k == 0, k == len - 1, 1'b0);
      end
   endtask

   // monitor: pops expectations whenever the DUT presents an output
   ent_t  me;
   oent_t mo;
   fent_t mf;
   always @(negedge clk) begin
      if (!done) begin
         while (wq.size() > 0 && wq[0].t < cyc) begin
            void'(wq.pop_front()); checks++; errors++;
            $display("FAIL wen_missing cyc=%0d got none expected a write", cyc);
         end
         while (rq.size() > 0 && rq[0].t < cyc) begin
            void'(rq.pop_front()); checks++; errors++;
            $display("FAIL ren_missing cyc=%0d got none expected a read", cyc);
         end
         while (oq.size() > 0 && oq[0].t < cyc) begin
            void'(oq.pop_front()); checks++; errors++;
            $display("FAIL rd_vld_missing cyc=%0d got none expected a read beat", cyc);
         end
         while (fq.size() > 0 && fq[0].t < cyc) void'(fq.pop_front());
         if (fq.size() > 0 && fq[0].t == cyc) begin
            mf = fq.pop_front();
            check("bank_full", int'(o_bank_full), mf.f);
            check("overflow", int'(o_overflow), int'(mf.o));
            check("frame_err", int'(o_frame_err), int'(mf.fe));
         end
         if (o_mem_wen === 1'b1) begin
            if (wq.size() == 0 || wq[0].t != cyc) begin
               checks++; errors++;
               $display("FAIL wen_unexpected cyc=%0d got wen=1 expected wen=0", cyc);
            end else begin
               me = wq.pop_front();
               check("waddr", int'(o_mem_waddr), me.a);
            end
         end
         if (o_mem_ren === 1'b1) begin
            if (rq.size() == 0 || rq[0].t != cyc) begin
               checks++; errors++;
               $display("FAIL ren_unexpected cyc=%0d got ren=1 expected ren=0", cyc);
            end else begin
               me = rq.pop_front();
               check("raddr", int'(o_mem_raddr), me.a);
            end
         end
         if (o_rd_vld === 1'b1) begin
            if (oq.size() == 0 || oq[0].t != cyc) begin
               checks++; errors++;
               $display("FAIL rd_vld_unexpected cyc=%0d got vld=1 expected vld=0", cyc);
            end else begin
               mo = oq.pop_front();
               check("rd_sop", int'(o_rd_sop), int'(mo.s));
               check("rd_eop", int'(o_rd_eop), int'(mo.e));
            end
         end
      end
   end

   initial begin
      model_reset();
      repeat (3) cyc_drive(1'b0, 1'b0, 1'b0, 1'b1);
      // continuous 8-beat symbols, always ready
      rdy_mode = 0;
      repeat (3) send_sym(8, 1'b0);
      idle(30);
      // three full-bank symbols with no readout: third one overflows
      rdy_mode = 1;
      repeat (3) send_sym(16, 1'b0);
      idle(5);
      rdy_mode = 0;
      idle(50);
      // single-beat symbol
      send_sym(1, 1'b0);
      idle(10);
      // toggling ready
      rdy_mode = 2;
      send_sym(6, 1'b0);
      idle(25);
      rdy_mode = 0;
      // sop on beat 3 restarts the symbol
      cyc_drive(1'b1, 1'b1, 1'b0, 1'b0);
      cyc_drive(1'b1, 1'b0, 1'b0, 1'b0);
      send_sym(5, 1'b0);
      idle(20);
      // bank exhausted, then eop without sop
      send_sym(DEPTH + 1, 1'b0);
      idle(5);
      cyc_drive(1'b1, 1'b0, 1'b1, 1'b0);
      idle(5);
      // reset mid-write
      cyc_drive(1'b1, 1'b1, 1'b0, 1'b0);
      repeat (3) cyc_drive(1'b1, 1'b0, 1'b0, 1'b0);
      cyc_drive(1'b0, 1'b0, 1'b0, 1'b1);
      send_sym(4, 1'b0);
      idle(20);
      // reset mid-read
      rdy_mode = 1;
      send_sym(10, 1'b0);
      idle(3);
      rdy_mode = 0;
      idle(4);
      cyc_drive(1'b0, 1'b0, 1'b0, 1'b1);
      idle(3);
      send_sym(3, 1'b0);
      idle(20);
      // randomized traffic
      for (int it = 0; it < 200; it++) begin
         int a;
         if (it % 10 == 0) rdy_mode = $urandom_range(0, 3);
         a = $urandom_range(0, 19);
         case (a)
            0: cyc_drive(1'b1, 1'b0, 1'b1, 1'b0);
            1: cyc_drive(1'b0, 1'b0, 1'b0, 1'b1);
            2: begin
               int k = $urandom_range(1, 4);
               for (int j = 0; j < k; j++) cyc_drive(1'b1, j == 0, 1'b0, 1'b0);
               send_sym($urandom_range(1, DEPTH), 1'b1);
            end
            3: send_sym(DEPTH + $urandom_range(1, 3), 1'b0);
            default: send_sym($urandom_range(1, DEPTH), 1'b1);
         endcase
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 6));
      end
      rdy_mode = 0;
      idle(4 * DEPTH + 20);
      @(negedge clk);
      done = 1'b1;
      check("wq_left", wq.size(), 0);
      check("rq_left", rq.size(), 0);
      check("oq_left", oq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/lp_buf_pingpong_ctrl.md
Name: lp_buf_pingpong_ctrl

Overview:
- Controller that sequences an external two-bank (ping-pong) simple-dual-port BRAM used to delay one symbol of PUSCH beam data by exactly one symbol period.
- Write side: captures a framed symbol stream and generates the write address and enable.
- Read side: once a bank holds a complete symbol, replays it under downstream back-pressure and regenerates vld/sop/eop aligned to the memory read latency.
- Overflow and framing errors are flagged, never silently merged.

Parameters:
- ADDR_WIDTH, 11, address bits per bank; bank depth = 2^ADDR_WIDTH beats.
- RD_LAT, 2, BRAM read latency in cycles (ren to data valid); allowed range 1..8.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_wr_vld  in  1  input beat valid
- i_wr_sop  in  1  first beat of symbol; qualified by i_wr_vld
- i_wr_eop  in  1  last beat of symbol; qualified by i_wr_vld; sop and eop together = 1-beat symbol
- i_rd_ready  in  1  downstream accepts a read beat this cycle
- o_mem_wen  out  1  BRAM write enable
- o_mem_waddr  out  ADDR_WIDTH+1  write address, MSB = bank
- o_mem_ren  out  1  BRAM read enable
- o_mem_raddr  out  ADDR_WIDTH+1  read address, MSB = bank
- o_rd_vld  out  1  read data valid, aligned to BRAM dout
- o_rd_sop  out  1  first read beat of symbol, aligned to BRAM dout
- o_rd_eop  out  1  last read beat of symbol, aligned to BRAM dout
- o_bank_full  out  2  bank holds a complete, unread symbol
- o_overflow  out  1  sticky: a symbol was dropped because its target bank was full
- o_frame_err  out  1  sticky: sop inside symbol, eop outside symbol, or length overrun

Behaviour:
- Reset (synchronous, i_reset=1 at a clock edge):
  - All outputs are 0.
  - wbank=0, rbank=0, both FSMs idle, all counters 0, sticky flags cleared.
  - Reset mid-symbol abandons the symbol; no partial bank is ever marked full.
- Write FSM, states W_IDLE / W_FILL / W_DROP:
  - W_IDLE, vld&sop, bank wbank not full: o_mem_wen=1 with waddr={wbank,0} in the same cycle (combinational from the inputs); wcnt<=1; go to W_FILL. If eop is also set, the symbol completes as in W_FILL with length 1.
  - W_IDLE, vld&sop, bank wbank full: no write; o_overflow<=1; go to W_DROP (straight back to W_IDLE if eop is also set).
  - W_IDLE, vld&eop without sop: ignored; o_frame_err<=1.
  - W_FILL, each vld beat: wen=1, waddr={wbank,wcnt}, wcnt++.
  - W_FILL, vld&eop: len[wbank]<=wcnt+1; full[wbank]<=1; wbank toggles; go to W_IDLE.
  - W_FILL, beat arriving with wcnt=2^ADDR_WIDTH (bank exhausted): not written; o_frame_err<=1; go to W_DROP.
  - W_FILL, vld&sop: current symbol abandoned (bank stays not-full); o_frame_err<=1; new symbol restarts at {wbank,0} in the same cycle.
  - W_DROP: all beats discarded; vld&eop returns to W_IDLE.
- Read FSM, states R_IDLE / R_RUN:
  - R_IDLE: when full[rbank]=1, go to R_RUN with rcnt=0. A bank marked full at the edge ending cycle N enters R_RUN at the edge ending cycle N+1; the first ren can occur in cycle N+2.
  - R_RUN: o_mem_ren = i_rd_ready (combinational); raddr={rbank,rcnt}; rcnt++ on each ren.
  - ren with rcnt=0 tags sop; ren with rcnt=len[rbank]-1 tags eop. On that eop ren: full[rbank]<=0, rbank toggles, go to R_IDLE.
  - i_rd_ready low: no ren; address holds.
- Output alignment: the ren/sop/eop tags pass through an RD_LAT-deep shift register to form o_rd_vld/o_rd_sop/o_rd_eop, exactly RD_LAT cycles after the matching ren.
- Simultaneous events:
  - Write setting full on one bank and read clearing the other bank in the same cycle: both take effect.
  - A bank cleared at the edge ending cycle N is writable by a sop in cycle N+1; a sop in cycle N still sees it full and is dropped.
  - Length of 1 beat: sop and eop carried on the same read beat.
- Addresses wrap only within a bank; the bank MSB is never changed by counter carry.

Test Plan:
- Continuous symbols of 8 beats, i_rd_ready=1, RD_LAT=2 -> each symbol is read in full starting 2 cycles after the end of its write and appears on o_rd_vld 2 cycles later. Banks alternate 0,1,0. Read addresses are 0x000..0x007, then 0x800..0x807. Flags stay 0.
- Three 16-beat symbols back-to-back with i_rd_ready=0 -> symbols 1 and 2 fill banks 0 and 1; symbol 3 is fully dropped with o_overflow=1 and o_bank_full=2'b11. Raising ready then reads symbol 1, then symbol 2.
- 1-beat symbol (sop&eop) -> one read beat with o_rd_vld=o_rd_sop=o_rd_eop=1; len=1.
- i_rd_ready toggling 1010... during a 6-beat read -> 6 ren pulses with contiguous addresses. sop is on the first beat and eop on the 6th; o_rd_vld mirrors ren delayed by RD_LAT.
- sop arriving at beat 3 of a symbol -> o_frame_err=1; the bank is not marked full; the new symbol restarts at address 0 and reads back with the correct length.
- i_reset asserted for one cycle mid-write and mid-read -> all outputs 0 on the next cycle; o_bank_full=0; the next sop is written to bank 0, address 0.
